// File: rtl/orsram_ctrl_pkg.sv
// Shared constants for the output-result SRAM controller: geometry defaults,
// sequencer state encodings and arbiter grant bit positions.
// No ports; imported by orsram_ctrl and orsram_rr_arb.
package orsram_ctrl_pkg;

  localparam int ORSRAM_SRAM_NUM = 8;  // number of banks (byte lanes)
  localparam int ORSRAM_AW       = 7;  // bank address width, depth 128
  localparam int ORSRAM_DW       = 8;  // bank data width

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  // Requester positions in the arbiter req/gnt vectors
  localparam int GNT_WR = 0;
  localparam int GNT_RD = 1;

endpackage

// File: rtl/orsram_rr_arb.sv
// Two-input round-robin arbiter (write vs read) with a single "last" flag.
// Latency: gnt is combinational on req/en/last; last updates on the grant edge.
// Backpressure: en low blocks all grants; a loser simply retries next cycle.
// Ports: clk, rst_n (async active-low), req[1:0] in, en in, gnt[1:0] one-hot out.
module orsram_rr_arb
  import orsram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // 1: read was granted most recently. Resets to read so write wins the first tie.
  logic r_last_rd;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[GNT_WR] && req[GNT_RD]) begin
        if (r_last_rd) gnt[GNT_WR] = 1'b1;
        else           gnt[GNT_RD] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last_rd <= 1'b1;
    else if (|gnt)   r_last_rd <= gnt[GNT_RD];
  end

endmodule

// File: rtl/orsram_ctrl.sv
// Sequencer + arbiter for the banked output-result SRAM: zero-fill, then serve writes/reads.
// Latency: grant at t drives SRAM pins at t+1; read data returned with rd_rvalid at t+2.
// Backpressure: ready is held low while clearing; rd_rvalid has no backpressure.
// Ports: clk, rst_n; clr_req/busy; wr_* and rd_* request channels; sram_* macro pins
// (all outputs registered) and sram_q returned combinationally as rd_rdata.
module orsram_ctrl
  import orsram_ctrl_pkg::*;
#(
  parameter int SRAM_NUM = ORSRAM_SRAM_NUM,
  parameter int AW       = ORSRAM_AW,
  parameter int DW       = ORSRAM_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_req,
  output logic                   busy,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [SRAM_NUM-1:0]    wr_mask,
  input  logic [SRAM_NUM*DW-1:0] wr_data,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [AW-1:0]          rd_addr,
  output logic                   rd_rvalid,
  output logic [SRAM_NUM*DW-1:0] rd_rdata,
  output logic                   sram_cen,
  output logic [SRAM_NUM-1:0]    sram_wen,
  output logic [SRAM_NUM*AW-1:0] sram_a,
  output logic [SRAM_NUM*DW-1:0] sram_d,
  input  logic [SRAM_NUM*DW-1:0] sram_q
);

  logic [0:0]             r_state;
  logic [AW-1:0]          r_cnt;
  logic                   r_cen;
  logic [SRAM_NUM-1:0]    r_wen;
  logic [SRAM_NUM*AW-1:0] r_a;
  logic [SRAM_NUM*DW-1:0] r_d;
  logic [1:0]             r_rv_sr;   // [0]: pins driven this cycle, [1]: data on sram_q

  logic                   w_serve;
  logic                   w_arb_en;
  logic                   w_cnt_last;
  logic [1:0]             w_gnt;

  assign w_serve    = (r_state == ST_SERVE);
  // A clr_req cycle gives no grant so the clear starts on a quiet macro.
  assign w_arb_en   = w_serve & ~clr_req;
  assign w_cnt_last = (r_cnt == {AW{1'b1}});

  orsram_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({rd_valid, wr_valid}),
    .en    (w_arb_en),
    .gnt   (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else if (!w_serve) begin
      // Counter wraps 127 -> 0 exactly on the exit cycle.
      r_cnt <= r_cnt + 1'b1;
      if (w_cnt_last) r_state <= ST_SERVE;
    end else if (clr_req) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end
  end

  // SRAM pin registers; address/data hold when no access is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cen <= 1'b1;
      r_wen <= '1;
      r_a   <= '0;
      r_d   <= '0;
    end else if (!w_serve) begin
      r_cen <= 1'b0;
      r_wen <= '0;
      r_a   <= {SRAM_NUM{r_cnt}};
      r_d   <= '0;
    end else if (w_gnt[GNT_WR]) begin
      r_cen <= 1'b0;
      r_wen <= ~wr_mask;   // unmasked banks do a discarded read
      r_a   <= {SRAM_NUM{wr_addr}};
      r_d   <= wr_data;
    end else if (w_gnt[GNT_RD]) begin
      r_cen <= 1'b0;
      r_wen <= '1;
      r_a   <= {SRAM_NUM{rd_addr}};
    end else begin
      r_cen <= 1'b1;
      r_wen <= '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rv_sr <= 2'b00;
    else        r_rv_sr <= {r_rv_sr[0], w_gnt[GNT_RD]};
  end

  assign busy      = ~w_serve;
  assign wr_ready  = w_gnt[GNT_WR];
  assign rd_ready  = w_gnt[GNT_RD];
  assign rd_rvalid = r_rv_sr[1];
  assign rd_rdata  = sram_q;
  assign sram_cen  = r_cen;
  assign sram_wen  = r_wen;
  assign sram_a    = r_a;
  assign sram_d    = r_d;

endmodule

// File: tb/tb_orsram_ctrl.sv
// Directed bench for orsram_ctrl with a behavioural single-port SRAM model.
// Table rows are one cycle each: inputs, expected readies, pins and read return.
module tb_orsram_ctrl;

  localparam int N  = 8;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int RW = N * DW;

  localparam logic [RW-1:0] D5  = 64'h0102030405060708;
  localparam logic [RW-1:0] DAA = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [RW-1:0] DA  = 64'h00000000AAAAAAAA;
  localparam logic [RW-1:0] DC  = 64'hDEADBEEFCAFEF00D;
  localparam logic [RW-1:0] D21 = 64'h1122334455667788;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_req, busy;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_rvalid;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [N-1:0]  wr_mask, sram_wen;
  logic [RW-1:0] wr_data, rd_rdata, sram_d, sram_q;
  logic [N*AW-1:0] sram_a;
  logic          sram_cen;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  orsram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  // Single-port macro: write lanes store d and echo it, other lanes read.
  logic [DW-1:0] mem [N][128];
  always @(posedge clk) begin
    if (!sram_cen) begin
      for (int i = 0; i < N; i++) begin
        if (!sram_wen[i]) begin
          mem[i][sram_a[i*AW +: AW]] <= sram_d[i*DW +: DW];
          sram_q[i*DW +: DW]         <= sram_d[i*DW +: DW];
        end else begin
          sram_q[i*DW +: DW] <= mem[i][sram_a[i*AW +: AW]];
        end
      end
    end
  end

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [N-1:0]  wm;
    logic [RW-1:0] wd;
    logic          rv;
    logic [AW-1:0] ra;
    logic          ewr;
    logic          erd;
    logic          ecen;
    logic [N-1:0]  ewen;
    logic          evld;
    logic [RW-1:0] edat;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic wv, input logic [AW-1:0] wa, input logic [N-1:0] wm,
                              input logic [RW-1:0] wd, input logic rv, input logic [AW-1:0] ra,
                              input logic ewr, input logic erd, input logic ecen,
                              input logic [N-1:0] ewen, input logic evld, input logic [RW-1:0] edat);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wm = wm; v.wd = wd; v.rv = rv; v.ra = ra;
    v.ewr = ewr; v.erd = erd; v.ecen = ecen; v.ewen = ewen; v.evld = evld; v.edat = edat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cen"},    64'(sram_cen),  64'd1);
    chk({tag, "_wen"},    64'(sram_wen),  64'hFF);
    chk({tag, "_a"},      64'(sram_a),    64'd0);
    chk({tag, "_d"},      64'(sram_d),    64'd0);
    chk({tag, "_busy"},   64'(busy),      64'd1);
    chk({tag, "_rvalid"}, 64'(rd_rvalid), 64'd0);
  endtask

  // Called in the first CLEAR cycle; checks n issued clear writes.
  task automatic run_clear(input int n);
    logic [AW-1:0] ka;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    #1;
    chk("clear_busy_start", 64'(busy), 64'd1);
    chk("clear_rdy_start", 64'({wr_ready, rd_ready}), 64'd0);
    for (int k = 0; k < n; k++) begin
      step();
      ka = k[AW-1:0];
      chk("clear_cen", 64'(sram_cen), 64'd0);
      chk("clear_wen", 64'(sram_wen), 64'd0);
      chk("clear_d",   64'(sram_d),   64'd0);
      chk("clear_a",   64'(sram_a),   64'({N{ka}}));
      chk("clear_busy", 64'(busy), (k < 127) ? 64'd1 : 64'd0);
      if (k < 127) chk("clear_rdy", 64'({wr_ready, rd_ready}), 64'd0);
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             wv  wa     wm     wd   rv  ra     ewr erd cen wen    vld edat
    tbl[0]  = mk(1, 7'd5,  8'hFF, D5,  0, 7'd0,  1, 0, 1, 8'hFF, 0, '0);
    tbl[1]  = mk(0, 7'd0,  8'h00, '0,  1, 7'd5,  0, 1, 0, 8'h00, 0, '0);
    tbl[2]  = mk(1, 7'd9,  8'h0F, DAA, 0, 7'd0,  1, 0, 0, 8'hFF, 0, '0);
    tbl[3]  = mk(0, 7'd0,  8'h00, '0,  1, 7'd9,  0, 1, 0, 8'hF0, 1, D5);
    tbl[4]  = mk(0, 7'd0,  8'h00, '0,  0, 7'd0,  0, 0, 0, 8'hFF, 0, '0);
    tbl[5]  = mk(0, 7'd0,  8'h00, '0,  0, 7'd0,  0, 0, 1, 8'hFF, 1, DA);
    tbl[6]  = mk(1, 7'd20, 8'hFF, DC,  1, 7'd5,  1, 0, 1, 8'hFF, 0, '0);
    tbl[7]  = mk(1, 7'd20, 8'hFF, DC,  1, 7'd5,  0, 1, 0, 8'h00, 0, '0);
    tbl[8]  = mk(1, 7'd20, 8'hFF, DC,  1, 7'd5,  1, 0, 0, 8'hFF, 0, '0);
    tbl[9]  = mk(1, 7'd20, 8'hFF, DC,  1, 7'd5,  0, 1, 0, 8'h00, 1, D5);
    tbl[10] = mk(1, 7'd20, 8'hFF, DC,  1, 7'd5,  1, 0, 0, 8'hFF, 0, '0);
    tbl[11] = mk(1, 7'd20, 8'hFF, DC,  1, 7'd5,  0, 1, 0, 8'h00, 1, D5);
    tbl[12] = mk(0, 7'd0,  8'h00, '0,  0, 7'd0,  0, 0, 0, 8'hFF, 0, '0);
    tbl[13] = mk(0, 7'd0,  8'h00, '0,  0, 7'd0,  0, 0, 1, 8'hFF, 1, D5);
    tbl[14] = mk(0, 7'd0,  8'h00, '0,  1, 7'd20, 0, 1, 1, 8'hFF, 0, '0);
    tbl[15] = mk(1, 7'd21, 8'hFF, D21, 1, 7'd21, 1, 0, 0, 8'hFF, 0, '0);
    tbl[16] = mk(1, 7'd21, 8'hFF, D21, 1, 7'd21, 0, 1, 0, 8'h00, 1, DC);
    tbl[17] = mk(0, 7'd0,  8'h00, '0,  0, 7'd0,  0, 0, 0, 8'hFF, 0, '0);
    tbl[18] = mk(0, 7'd0,  8'h00, '0,  0, 7'd0,  0, 0, 1, 8'hFF, 1, D21);

    rst_n = 1'b0; clr_req = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0;

    // Reset state
    step(); step();
    wr_valid = 1'b1;
    #1;
    chk_reset("rst");
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    wr_valid = 1'b0;

    // Release reset: full zero-fill, busy falls after 128 issued rows
    rst_n = 1'b1;
    run_clear(128);
    step();

    // Table: write/read, masked write, contention, tie after single grant, RAW hazard
    for (int i = 0; i < 19; i++) begin
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_mask = tbl[i].wm; wr_data = tbl[i].wd;
      rd_valid = tbl[i].rv; rd_addr = tbl[i].ra;
      #1;
      chk($sformatf("row%0d_wr_ready", i), 64'(wr_ready), 64'(tbl[i].ewr));
      chk($sformatf("row%0d_rd_ready", i), 64'(rd_ready), 64'(tbl[i].erd));
      chk($sformatf("row%0d_cen", i), 64'(sram_cen), 64'(tbl[i].ecen));
      chk($sformatf("row%0d_wen", i), 64'(sram_wen), 64'(tbl[i].ewen));
      chk($sformatf("row%0d_rvalid", i), 64'(rd_rvalid), 64'(tbl[i].evld));
      if (tbl[i].evld) chk($sformatf("row%0d_rdata", i), rd_rdata, tbl[i].edat);
      step();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;

    // Read granted the cycle before clr_req still returns its data
    rd_valid = 1'b1; rd_addr = 7'd5;
    #1;
    chk("clr_pre_rd_ready", 64'(rd_ready), 64'd1);
    step();
    rd_valid = 1'b0; clr_req = 1'b1;
    wr_valid = 1'b1; wr_addr = 7'd5; wr_mask = 8'hFF; wr_data = DC;
    #1;
    chk("clr_cycle_rdy", 64'({wr_ready, rd_ready}), 64'd0);
    chk("clr_cycle_busy", 64'(busy), 64'd0);
    step();
    clr_req = 1'b0; wr_valid = 1'b0;
    #1;
    chk("clr_inflight_rvalid", 64'(rd_rvalid), 64'd1);
    chk("clr_inflight_rdata", rd_rdata, D5);
    run_clear(128);

    // Grant possible in the first SERVE cycle; cleared row reads zero
    rd_valid = 1'b1; rd_addr = 7'd5;
    #1;
    chk("post_clr_rd_ready", 64'(rd_ready), 64'd1);
    step();
    rd_valid = 1'b0;
    chk("post_clr_rvalid_t1", 64'(rd_rvalid), 64'd0);
    step();
    chk("post_clr_rvalid_t2", 64'(rd_rvalid), 64'd1);
    chk("post_clr_rdata", rd_rdata, 64'd0);

    // Reset mid-read drops the pending rd_rvalid
    step();
    rd_valid = 1'b1; rd_addr = 7'd21;
    #1;
    chk("midrd_rd_ready", 64'(rd_ready), 64'd1);
    step();
    rd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("midrd");
    step();
    chk("midrd_dropped_rvalid", 64'(rd_rvalid), 64'd0);
    step();
    rst_n = 1'b1;

    // Reset at clear cycle 60 restarts the clear from address 0
    run_clear(60);
    rst_n = 1'b0;
    #1;
    chk_reset("midclr");
    step();
    rst_n = 1'b1;
    run_clear(128);

    // last flag back at "read": write wins the first tie
    wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    chk("tie_after_rst", 64'({rd_ready, wr_ready}), 64'b01);
    wr_valid = 1'b0; rd_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
